dp_template_scheduler: RTL and testbench

//  Time-shares one DP matching engine across NTMP stored keyword templates. Each accepted feature frame
//  is issued to the engine once per template in index order. Each score/length pair is checked against
//  the detection threshold, and one decision per frame is reported with the best matching template.

---
 rtl/dp_template_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_dp_template_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_template_scheduler.sv
// Shares one DP matching engine across NTMP keyword templates, one engine pass per template
// per frame, and reports the best-scoring hit. Also generates the hang-over VAD output.
module dp_template_scheduler #(
    parameter int BIT      = 32,
    parameter int NTMP     = 4,
    parameter int TW       = 2,
    parameter int VAD_HANG = 3000000,
    parameter int CNTW     = 22,
    parameter int TIMEOUT  = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic signed [BIT-1:0] vec_in,
    input  logic                  dv_in,
    input  logic                  vad_in,
    input  logic [BIT+5:0]        detected_scr,
    output logic signed [BIT-1:0] eng_vec,
    output logic                  eng_dv,
    output logic [TW-1:0]         eng_sel,
    output logic                  eng_clr,
    input  logic                  eng_done,
    input  logic [BIT+12:0]       eng_scr,
    input  logic [6:0]            eng_len,
    output logic                  result_dv,
    output logic                  result,
    output logic [TW-1:0]         best_idx,
    output logic [BIT+12:0]       best_scr,
    output logic                  vad_out,
    output logic                  busy,
    output logic                  overflow,
    output logic                  timeout_err
);

    localparam int SW = BIT + 13;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EVAL, REPORT, CLEAR} state_t;

    state_t                state;
    logic                  pend_v;
    logic signed [BIT-1:0] pend_vec;
    logic [TW-1:0]         t;
    logic [WW-1:0]         wcnt;
    logic [SW-1:0]         cap_scr;
    logic [6:0]            cap_len;
    logic                  cap_ok;
    logic                  found;
    logic [TW-1:0]         fnd_idx;
    logic [SW-1:0]         fnd_scr;
    logic [CNTW-1:0]       vcnt;

    logic                  consume;
    logic [SW-1:0]         prod;
    logic                  hit_t;
    logic                  take;

    assign consume = (state == IDLE) && pend_v;

    always_comb begin
        prod  = SW'(cap_len) * SW'(detected_scr);
        hit_t = cap_ok && (cap_scr != '1) && (cap_len != '0) && (cap_scr < prod);
        // strict compare keeps the lower index on equal scores
        take  = hit_t && (!found || (cap_scr < fnd_scr));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_v   <= 1'b0;
            pend_vec <= '0;
            overflow <= 1'b0;
        end else begin
            if (dv_in && (!pend_v || consume)) begin
                pend_v   <= 1'b1;
                pend_vec <= vec_in;
            end else begin
                if (consume) pend_v <= 1'b0;
                if (dv_in) overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            eng_vec     <= '0;
            eng_dv      <= 1'b0;
            eng_sel     <= '0;
            eng_clr     <= 1'b0;
            result_dv   <= 1'b0;
            result      <= 1'b0;
            best_idx    <= '0;
            best_scr    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            t           <= '0;
            wcnt        <= '0;
            cap_scr     <= '0;
            cap_len     <= '0;
            cap_ok      <= 1'b0;
            found       <= 1'b0;
            fnd_idx     <= '0;
            fnd_scr     <= '0;
        end else begin
            eng_dv    <= 1'b0;
            eng_clr   <= 1'b0;
            result_dv <= 1'b0;
            case (state)
                IDLE: begin
                    if (pend_v) begin
                        eng_vec <= pend_vec;
                        t       <= '0;
                        eng_sel <= '0;
                        eng_dv  <= 1'b1;
                        found   <= 1'b0;
                        fnd_idx <= '0;
                        fnd_scr <= '0;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    wcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (eng_done) begin
                        cap_scr <= eng_scr;
                        cap_len <= eng_len;
                        cap_ok  <= 1'b1;
                        state   <= EVAL;
                    end else if (wcnt == WW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        cap_ok      <= 1'b0;
                        state       <= EVAL;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                EVAL: begin
                    if (take) begin
                        found   <= 1'b1;
                        fnd_idx <= t;
                        fnd_scr <= cap_scr;
                    end
                    if (t == TW'(NTMP - 1)) begin
                        // decision folds in this last template's update directly
                        result_dv <= 1'b1;
                        result    <= found || take;
                        best_idx  <= take ? t : (found ? fnd_idx : '0);
                        best_scr  <= take ? cap_scr : (found ? fnd_scr : '0);
                        state     <= REPORT;
                    end else begin
                        t       <= t + 1'b1;
                        eng_sel <= t + 1'b1;
                        eng_dv  <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                REPORT: begin
                    if (found) begin
                        eng_clr <= 1'b1;
                        state   <= CLEAR;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                CLEAR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vad_out <= 1'b0;
            vcnt    <= '0;
        end else if (!vad_out) begin
            if (vad_in) begin
                vad_out <= 1'b1;
                vcnt    <= '0;
            end
        end else if (vad_in) begin
            vcnt <= '0;
        end else if (vcnt == CNTW'(VAD_HANG - 1)) begin
            vad_out <= 1'b0;
            vcnt    <= '0;
        end else begin
            vcnt <= vcnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dp_template_scheduler.sv
// Directed bench for dp_template_scheduler: behavioural engine, per-frame decision model and
// a window-based VAD model, checked against the DUT on every meaningful cycle.
module tb_dp_template_scheduler;

    localparam int BIT      = 32;
    localparam int NTMP     = 4;
    localparam int TW       = 2;
    localparam int VAD_HANG = 5;
    localparam int CNTW     = 4;
    localparam int TIMEOUT  = 1023;
    localparam int SW       = BIT + 13;
    localparam logic [SW-1:0] INV = '1;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [BIT-1:0]  vec_in = '0;
    logic            dv_in = 1'b0;
    logic            vad_in = 1'b0;
    logic [BIT+5:0]  detected_scr = '0;
    logic [BIT-1:0]  eng_vec;
    logic            eng_dv;
    logic [TW-1:0]   eng_sel;
    logic            eng_clr;
    logic            eng_done = 1'b0;
    logic [SW-1:0]   eng_scr = '0;
    logic [6:0]      eng_len = '0;
    logic            result_dv;
    logic            result;
    logic [TW-1:0]   best_idx;
    logic [SW-1:0]   best_scr;
    logic            vad_out;
    logic            busy;
    logic            overflow;
    logic            timeout_err;

    always #5 clk = ~clk;

    dp_template_scheduler #(
        .BIT(BIT), .NTMP(NTMP), .TW(TW), .VAD_HANG(VAD_HANG), .CNTW(CNTW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .vec_in(vec_in), .dv_in(dv_in), .vad_in(vad_in),
        .detected_scr(detected_scr), .eng_vec(eng_vec), .eng_dv(eng_dv), .eng_sel(eng_sel),
        .eng_clr(eng_clr), .eng_done(eng_done), .eng_scr(eng_scr), .eng_len(eng_len),
        .result_dv(result_dv), .result(result), .best_idx(best_idx), .best_scr(best_scr),
        .vad_out(vad_out), .busy(busy), .overflow(overflow), .timeout_err(timeout_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // engine behaviour tables
    logic [SW-1:0] scr_tab [NTMP];
    logic [6:0]    len_tab [NTMP];
    bit            no_done [NTMP];
    int            eng_delay = 1;

    task automatic set_tab(input int i, input logic [SW-1:0] s, input logic [6:0] l);
        scr_tab[i] = s;
        len_tab[i] = l;
        no_done[i] = 1'b0;
    endtask

    task automatic set_t1;
        set_tab(0, 500, 60);
        set_tab(1, 300, 40);
        set_tab(2, 200, 25);
        set_tab(3, 900, 50);
    endtask

    initial begin
        logic [TW-1:0] sel;
        forever begin
            @(negedge clk);
            if (eng_dv && !no_done[eng_sel]) begin
                sel = eng_sel;
                repeat (eng_delay) @(negedge clk);
                eng_done = 1'b1;
                eng_scr  = scr_tab[sel];
                eng_len  = len_tab[sel];
                @(negedge clk);
                eng_done = 1'b0;
            end
        end
    end

    // expected per-frame decisions
    logic [BIT-1:0] frame_q [$];
    bit             res_q   [$];
    logic [TW-1:0]  idx_q   [$];
    logic [SW-1:0]  scr_q   [$];

    task automatic model_push(input logic [BIT-1:0] v);
        bit            any;
        int            bi;
        logic [SW-1:0] bs;
        logic [SW-1:0] p;
        bit            ok;
        any = 1'b0;
        bi  = 0;
        bs  = '0;
        for (int i = 0; i < NTMP; i++) begin
            ok = !no_done[i] && (scr_tab[i] != INV) && (len_tab[i] != 0);
            p  = SW'(len_tab[i]) * SW'(detected_scr);
            if (ok && scr_tab[i] < p && (!any || scr_tab[i] < bs)) begin
                any = 1'b1;
                bi  = i;
                bs  = scr_tab[i];
            end
        end
        frame_q.push_back(v);
        res_q.push_back(any);
        idx_q.push_back(bi[TW-1:0]);
        scr_q.push_back(bs);
    endtask

    int exp_sel = 0;
    int res_cnt = 0;
    int clr_cnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (eng_dv) begin
                check("frame_pending", 64'(frame_q.size() > 0), 1);
                if (frame_q.size() > 0) begin
                    check("eng_sel", 64'(eng_sel), 64'(exp_sel));
                    check("eng_vec", 64'(eng_vec), 64'(frame_q[0]));
                end
                exp_sel++;
            end
            if (eng_clr) clr_cnt++;
            if (result_dv) begin
                res_cnt++;
                check("decision_expected", 64'(res_q.size() > 0), 1);
                if (res_q.size() > 0) begin
                    check("passes_per_frame", 64'(exp_sel), 64'(NTMP));
                    check("result", 64'(result), 64'(res_q[0]));
                    check("best_idx", 64'(best_idx), 64'(idx_q[0]));
                    check("best_scr", 64'(best_scr), 64'(scr_q[0]));
                    void'(frame_q.pop_front());
                    void'(res_q.pop_front());
                    void'(idx_q.pop_front());
                    void'(scr_q.pop_front());
                end
                exp_sel = 0;
            end
        end
    end

    // vad_out is high iff vad_in was seen high within the last VAD_HANG samples
    int since = 0;
    bit seen  = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            seen  = 1'b0;
            since = 0;
        end else if (vad_in) begin
            seen  = 1'b1;
            since = 0;
        end else if (since < 1000) begin
            since++;
        end
    end

    always @(negedge clk) begin
        if (reset) check("vad_out", 64'(vad_out), 64'(seen && since < VAD_HANG));
    end

    task automatic send_frame(input logic [BIT-1:0] v);
        model_push(v);
        vec_in = v;
        dv_in  = 1'b1;
        @(negedge clk);
        dv_in  = 1'b0;
    endtask

    task automatic wait_results(input int target, input int budget);
        int c;
        c = 0;
        while (res_cnt < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("result_wait", 64'(res_cnt >= target), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_eng_vec"}, 64'(eng_vec), 0);
        check({name, "_others"},
              64'({eng_dv, eng_sel, eng_clr, result_dv, result, best_idx, best_scr,
                   vad_out, busy, overflow, timeout_err}), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r0;
        int c0;
        int c;
        detected_scr = 38'd10;
        set_t1();
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        reset = 1'b1;
        @(negedge clk);

        // T1: distinct scores, template 2 wins; also pins dv_in -> eng_dv latency
        r0 = res_cnt; c0 = clr_cnt;
        model_push(32'hDEAD_0001);
        vec_in = 32'hDEAD_0001;
        dv_in  = 1'b1;
        @(negedge clk);
        dv_in  = 1'b0;
        check("lat_first_cycle_eng_dv", 64'(eng_dv), 0);
        @(negedge clk);
        check("lat_second_cycle_eng_dv", 64'(eng_dv), 1);
        check("busy_during_frame", 64'(busy), 1);
        wait_results(r0 + 1, 200);
        check("t1_result", 64'(result), 1);
        check("t1_best_idx", 64'(best_idx), 2);
        check("t1_best_scr", 64'(best_scr), 200);
        check("t1_clr_pulses", 64'(clr_cnt - c0), 1);
        check("t1_busy_idle", 64'(busy), 0);

        // T2: nothing valid, best fields return to 0, no clear
        r0 = res_cnt; c0 = clr_cnt;
        set_tab(0, INV, 10);
        set_tab(1, 5, 0);
        set_tab(2, INV, 0);
        set_tab(3, 1, 0);
        eng_delay = 2;
        send_frame(32'hFFFF_FF80);
        wait_results(r0 + 1, 200);
        check("t2_result", 64'(result), 0);
        check("t2_best_idx", 64'(best_idx), 0);
        check("t2_best_scr", 64'(best_scr), 0);
        check("t2_clr_pulses", 64'(clr_cnt - c0), 0);

        // T3: equal scores on templates 1 and 3, lower index kept
        r0 = res_cnt; c0 = clr_cnt;
        set_tab(0, INV, 5);
        set_tab(1, 100, 20);
        set_tab(2, 0, 0);
        set_tab(3, 100, 20);
        eng_delay = 3;
        send_frame(32'h1234_5678);
        wait_results(r0 + 1, 200);
        check("t3_best_idx", 64'(best_idx), 1);
        check("t3_best_scr", 64'(best_scr), 100);
        check("t3_clr_pulses", 64'(clr_cnt - c0), 1);
        check("t3_no_overflow", 64'(overflow), 0);

        // T4: back-to-back frames: one in flight, one buffered, one dropped
        r0 = res_cnt; c0 = clr_cnt;
        set_t1();
        eng_delay = 1;
        model_push(32'h0000_00A1);
        model_push(32'h0000_00B2);
        dv_in = 1'b1;
        vec_in = 32'h0000_00A1;
        @(negedge clk);
        vec_in = 32'h0000_00B2;
        @(negedge clk);
        vec_in = 32'h0000_00C3;
        @(negedge clk);
        dv_in = 1'b0;
        check("t4_overflow", 64'(overflow), 1);
        wait_results(r0 + 2, 400);
        repeat (20) @(negedge clk);
        check("t4_result_pulses", 64'(res_cnt - r0), 2);
        check("t4_clr_pulses", 64'(clr_cnt - c0), 2);
        check("t4_overflow_sticky", 64'(overflow), 1);

        // T5: template 1 never answers
        r0 = res_cnt;
        check("t5_timeout_clear_before", 64'(timeout_err), 0);
        no_done[1] = 1'b1;
        send_frame(32'h5555_AAAA);
        repeat (1000) @(negedge clk);
        check("t5_no_early_timeout", 64'(timeout_err), 0);
        wait_results(r0 + 1, 500);
        check("t5_timeout_err", 64'(timeout_err), 1);
        check("t5_result", 64'(result), 1);
        check("t5_best_idx", 64'(best_idx), 2);
        check("t5_best_scr", 64'(best_scr), 200);
        no_done[1] = 1'b0;

        // T6: VAD hang-over
        vad_in = 1'b1;
        @(negedge clk);
        vad_in = 1'b0;
        check("vad_rise", 64'(vad_out), 1);
        repeat (4) @(negedge clk);
        check("vad_hold_4_low", 64'(vad_out), 1);
        @(negedge clk);
        check("vad_fall_5_low", 64'(vad_out), 0);
        vad_in = 1'b1;
        repeat (3) @(negedge clk);
        vad_in = 1'b0;
        repeat (2) @(negedge clk);
        vad_in = 1'b1;
        @(negedge clk);
        vad_in = 1'b0;
        repeat (8) @(negedge clk);

        // T6: reset in the middle of WAIT, then a fresh frame
        eng_delay = 40;
        send_frame(32'hCAFE_0006);
        c = 0;
        while (!eng_dv && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("t6_issue_seen", 64'(eng_dv), 1);
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("t6_async_reset");
        frame_q.delete();
        res_q.delete();
        idx_q.delete();
        scr_q.delete();
        exp_sel = 0;
        @(negedge clk);
        reset = 1'b1;
        repeat (50) @(negedge clk);
        check("t6_idle_after_reset", 64'(busy), 0);
        r0 = res_cnt; c0 = clr_cnt;
        eng_delay = 1;
        send_frame(32'hCAFE_0007);
        wait_results(r0 + 1, 200);
        check("t6_result", 64'(result), 1);
        check("t6_best_idx", 64'(best_idx), 2);
        check("t6_clr_pulses", 64'(clr_cnt - c0), 1);
        check("t6_sticky_cleared", 64'({overflow, timeout_err}), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
